// File: rtl/cpu_common.sv
// Shared core types: legacy SP stepping codes plus the parametrised
// stack-pointer unit's operation and fault encodings.
package cpu_common;

  typedef enum logic [2:0] {
    SP_NONE,
    SP_INC_1,
    SP_INC_2,
    SP_DEC_1,
    SP_DEC_2
  } sp_operation_t;

  typedef enum logic [1:0] {
    SPU_NOP,
    SPU_PUSH,
    SPU_POP,
    SPU_LOAD
  } sp_unit_op_t;

  typedef enum logic [1:0] {
    SPF_NONE,
    SPF_OVERFLOW,
    SPF_UNDERFLOW,
    SPF_BAD_LOAD
  } sp_fault_t;

endpackage

// File: rtl/sp_bound_check.sv
// Combinational next-SP computation and bound check for one stack op.
// Downward-growing stack: push pre-decrements, pop post-increments.
module sp_bound_check
  import cpu_common::*;
#(
  parameter int SP_WIDTH   = 16,
  parameter int STEP_WIDTH = 3
) (
  input  sp_unit_op_t           op,
  input  logic [SP_WIDTH-1:0]   sp,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [SP_WIDTH-1:0]   load_val,
  input  logic [SP_WIDTH-1:0]   limit_lo,
  input  logic [SP_WIDTH-1:0]   limit_hi,
  output logic [SP_WIDTH-1:0]   next_sp,
  output logic                  legal,
  output sp_fault_t             cause
);

  logic [SP_WIDTH:0] sp_x;
  logic [SP_WIDTH:0] step_x;
  logic [SP_WIDTH:0] dif;
  logic [SP_WIDTH:0] sum;
  logic [SP_WIDTH:0] last;
  logic              step_nz;

  assign sp_x    = {1'b0, sp};
  assign step_x  = {{(SP_WIDTH+1-STEP_WIDTH){1'b0}}, step};
  assign dif     = sp_x - step_x;
  assign sum     = sp_x + step_x;
  // highest byte address actually popped
  assign last    = sum - {{SP_WIDTH{1'b0}}, 1'b1};
  assign step_nz = |step;

  always_comb begin
    next_sp = sp;
    legal   = 1'b1;
    cause   = SPF_NONE;
    unique case (op)
      SPU_PUSH: begin
        if (step_nz) begin
          if (dif[SP_WIDTH] || (dif[SP_WIDTH-1:0] < limit_lo)) begin
            legal = 1'b0;
            cause = SPF_OVERFLOW;
          end else begin
            next_sp = dif[SP_WIDTH-1:0];
          end
        end
      end
      SPU_POP: begin
        if (step_nz) begin
          if (sum[SP_WIDTH] || (last > {1'b0, limit_hi})) begin
            legal = 1'b0;
            cause = SPF_UNDERFLOW;
          end else begin
            next_sp = sum[SP_WIDTH-1:0];
          end
        end
      end
      SPU_LOAD: begin
        if ((load_val < limit_lo) || (load_val > limit_hi)) begin
          legal = 1'b0;
          cause = SPF_BAD_LOAD;
        end else begin
          next_sp = load_val;
        end
      end
      SPU_NOP: begin
        next_sp = sp;
      end
    endcase
  end

endmodule

// File: rtl/sp_unit.sv
// Stack-pointer unit: variable-step push/pop, direct load, programmable
// bounds, sticky RUN/FAULT state and a high-water-mark tracker.
module sp_unit
  import cpu_common::*;
#(
  parameter int                  SP_WIDTH   = 16,
  parameter int                  STEP_WIDTH = 3,
  parameter logic [SP_WIDTH-1:0] RESET_SP   = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst_async,
  input  sp_unit_op_t           op,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic [SP_WIDTH-1:0]   load_val,
  input  logic                  cfg_we,
  input  logic [SP_WIDTH-1:0]   cfg_lo,
  input  logic [SP_WIDTH-1:0]   cfg_hi,
  input  logic                  fault_clear,
  output logic [SP_WIDTH-1:0]   sp,
  output logic [SP_WIDTH-1:0]   stack_addr,
  output logic [SP_WIDTH-1:0]   depth,
  output logic [SP_WIDTH-1:0]   hwm,
  output logic                  faulted,
  output sp_fault_t             fault_cause
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FAULT = 1'b1;

  logic [0:0]          state;
  logic [0:0]          state_n;
  logic [SP_WIDTH-1:0] limit_lo;
  logic [SP_WIDTH-1:0] limit_hi;
  logic [SP_WIDTH-1:0] lo_n;
  logic [SP_WIDTH-1:0] hi_n;
  logic [SP_WIDTH-1:0] sp_n;
  logic [SP_WIDTH-1:0] hwm_n;
  logic [SP_WIDTH-1:0] hwm_base;
  logic [SP_WIDTH-1:0] chk_sp;
  logic                chk_legal;
  sp_fault_t           chk_cause;
  sp_fault_t           cause_n;

  sp_bound_check #(
    .SP_WIDTH  (SP_WIDTH),
    .STEP_WIDTH(STEP_WIDTH)
  ) u_chk (
    .op      (op),
    .sp      (sp),
    .step    (step),
    .load_val(load_val),
    .limit_lo(limit_lo),
    .limit_hi(limit_hi),
    .next_sp (chk_sp),
    .legal   (chk_legal),
    .cause   (chk_cause)
  );

  always_comb begin
    stack_addr = sp;
    unique case (op)
      SPU_PUSH: stack_addr = sp - {{(SP_WIDTH-STEP_WIDTH){1'b0}}, step};
      SPU_LOAD: stack_addr = load_val;
      SPU_POP:  stack_addr = sp;
      SPU_NOP:  stack_addr = sp;
    endcase
  end

  always_comb begin
    state_n  = state;
    cause_n  = fault_cause;
    sp_n     = sp;
    lo_n     = cfg_we ? cfg_lo : limit_lo;
    hi_n     = cfg_we ? cfg_hi : limit_hi;
    hwm_base = fault_clear ? sp : hwm;
    if (state == RUN) begin
      if (chk_legal) begin
        sp_n = chk_sp;
      end else begin
        state_n = FAULT;
        cause_n = chk_cause;
      end
    end else if (fault_clear) begin
      state_n = RUN;
      cause_n = SPF_NONE;
    end
    hwm_n = (sp_n < hwm_base) ? sp_n : hwm_base;
  end

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state       <= RUN;
      fault_cause <= SPF_NONE;
      sp          <= RESET_SP;
      limit_lo    <= '0;
      limit_hi    <= '1;
      hwm         <= RESET_SP;
      depth       <= {SP_WIDTH{1'b1}} - RESET_SP;
    end else begin
      state       <= state_n;
      fault_cause <= cause_n;
      sp          <= sp_n;
      limit_lo    <= lo_n;
      limit_hi    <= hi_n;
      hwm         <= hwm_n;
      depth       <= hi_n - sp_n;
    end
  end

  assign faulted = (state == FAULT);

endmodule

// File: tb/tb_sp_unit.sv
// Directed testbench for sp_unit: reset, push/pop, faults, limits, hwm.
module tb_sp_unit;
  import cpu_common::*;

  logic        clk = 1'b0;
  logic        rst_async;
  sp_unit_op_t op;
  logic [2:0]  step;
  logic [15:0] load_val;
  logic        cfg_we;
  logic [15:0] cfg_lo;
  logic [15:0] cfg_hi;
  logic        fault_clear;
  logic [15:0] sp;
  logic [15:0] stack_addr;
  logic [15:0] depth;
  logic [15:0] hwm;
  logic        faulted;
  sp_fault_t   fault_cause;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sp_unit #(
    .SP_WIDTH  (16),
    .STEP_WIDTH(3),
    .RESET_SP  (16'hFFFF)
  ) dut (
    .clk        (clk),
    .rst_async  (rst_async),
    .op         (op),
    .step       (step),
    .load_val   (load_val),
    .cfg_we     (cfg_we),
    .cfg_lo     (cfg_lo),
    .cfg_hi     (cfg_hi),
    .fault_clear(fault_clear),
    .sp         (sp),
    .stack_addr (stack_addr),
    .depth      (depth),
    .hwm        (hwm),
    .faulted    (faulted),
    .fault_cause(fault_cause)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op          = SPU_NOP;
    step        = 3'd0;
    load_val    = 16'h0;
    cfg_we      = 1'b0;
    cfg_lo      = 16'h0;
    cfg_hi      = 16'h0;
    fault_clear = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_async = 1'b0;
    tick();
    tick();
    rst_async = 1'b1;
    tick();
    n_tests++; if (sp !== 16'hFFFF) begin n_fail++; $display("FAIL reset_sp got %h exp FFFF", sp); end
    n_tests++; if (depth !== 16'h0) begin n_fail++; $display("FAIL reset_depth got %h exp 0000", depth); end
    n_tests++; if (hwm !== 16'hFFFF) begin n_fail++; $display("FAIL reset_hwm got %h exp FFFF", hwm); end
    n_tests++; if (faulted !== 1'b0) begin n_fail++; $display("FAIL reset_faulted got %b exp 0", faulted); end
    n_tests++; if (fault_cause !== SPF_NONE) begin n_fail++; $display("FAIL reset_cause got %0d exp 0", fault_cause); end
  endtask

  task automatic test_push_pop();
    op = SPU_PUSH; step = 3'd2;
    #1;
    n_tests++; if (stack_addr !== 16'hFFFD) begin n_fail++; $display("FAIL push_addr got %h exp FFFD", stack_addr); end
    tick();
    n_tests++; if (sp !== 16'hFFFD) begin n_fail++; $display("FAIL push_sp got %h exp FFFD", sp); end
    n_tests++; if (depth !== 16'h0002) begin n_fail++; $display("FAIL push_depth got %h exp 0002", depth); end
    n_tests++; if (hwm !== 16'hFFFD) begin n_fail++; $display("FAIL push_hwm got %h exp FFFD", hwm); end
    op = SPU_POP; step = 3'd2;
    #1;
    n_tests++; if (stack_addr !== 16'hFFFD) begin n_fail++; $display("FAIL pop_addr got %h exp FFFD", stack_addr); end
    tick();
    n_tests++; if (sp !== 16'hFFFF) begin n_fail++; $display("FAIL pop_sp got %h exp FFFF", sp); end
    n_tests++; if (hwm !== 16'hFFFD) begin n_fail++; $display("FAIL pop_hwm got %h exp FFFD", hwm); end
    n_tests++; if (depth !== 16'h0000) begin n_fail++; $display("FAIL pop_depth got %h exp 0000", depth); end
    idle();
  endtask

  task automatic test_overflow();
    idle(); cfg_we = 1'b1; cfg_lo = 16'h0100; cfg_hi = 16'h01FF;
    tick();
    idle(); op = SPU_LOAD; load_val = 16'h0101;
    #1;
    n_tests++; if (stack_addr !== 16'h0101) begin n_fail++; $display("FAIL load_addr got %h exp 0101", stack_addr); end
    tick();
    n_tests++; if (sp !== 16'h0101) begin n_fail++; $display("FAIL ovf_setup_sp got %h exp 0101", sp); end
    idle(); op = SPU_PUSH; step = 3'd2;
    tick();
    n_tests++; if (faulted !== 1'b1) begin n_fail++; $display("FAIL ovf_faulted got %b exp 1", faulted); end
    n_tests++; if (fault_cause !== SPF_OVERFLOW) begin n_fail++; $display("FAIL ovf_cause got %0d exp 1", fault_cause); end
    n_tests++; if (sp !== 16'h0101) begin n_fail++; $display("FAIL ovf_sp got %h exp 0101", sp); end
    op = SPU_POP; step = 3'd2;
    tick();
    n_tests++; if (sp !== 16'h0101) begin n_fail++; $display("FAIL fault_ignore_sp got %h exp 0101", sp); end
    n_tests++; if (fault_cause !== SPF_OVERFLOW) begin n_fail++; $display("FAIL fault_hold_cause got %0d exp 1", fault_cause); end
    idle(); fault_clear = 1'b1;
    tick();
    idle();
    n_tests++; if (faulted !== 1'b0) begin n_fail++; $display("FAIL clr_faulted got %b exp 0", faulted); end
    n_tests++; if (fault_cause !== SPF_NONE) begin n_fail++; $display("FAIL clr_cause got %0d exp 0", fault_cause); end
    n_tests++; if (hwm !== 16'h0101) begin n_fail++; $display("FAIL clr_hwm got %h exp 0101", hwm); end
  endtask

  task automatic test_underflow();
    idle(); op = SPU_LOAD; load_val = 16'h01FE;
    tick();
    idle(); op = SPU_POP; step = 3'd2;
    tick();
    n_tests++; if (faulted !== 1'b0) begin n_fail++; $display("FAIL pop_edge_faulted got %b exp 0", faulted); end
    n_tests++; if (sp !== 16'h0200) begin n_fail++; $display("FAIL pop_edge_sp got %h exp 0200", sp); end
    n_tests++; if (depth !== 16'hFFFF) begin n_fail++; $display("FAIL pop_edge_depth got %h exp FFFF", depth); end
    op = SPU_POP; step = 3'd1;
    tick();
    n_tests++; if (fault_cause !== SPF_UNDERFLOW) begin n_fail++; $display("FAIL unf_cause got %0d exp 2", fault_cause); end
    n_tests++; if (sp !== 16'h0200) begin n_fail++; $display("FAIL unf_sp got %h exp 0200", sp); end
    idle(); fault_clear = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_load();
    op = SPU_LOAD; load_val = 16'h0050;
    tick();
    n_tests++; if (fault_cause !== SPF_BAD_LOAD) begin n_fail++; $display("FAIL badload_cause got %0d exp 3", fault_cause); end
    n_tests++; if (sp !== 16'h0200) begin n_fail++; $display("FAIL badload_sp got %h exp 0200", sp); end
    idle(); fault_clear = 1'b1;
    tick();
    idle(); op = SPU_LOAD; load_val = 16'h0150;
    tick();
    idle();
    n_tests++; if (sp !== 16'h0150) begin n_fail++; $display("FAIL load_sp got %h exp 0150", sp); end
    n_tests++; if (hwm !== 16'h0150) begin n_fail++; $display("FAIL load_hwm got %h exp 0150", hwm); end
    n_tests++; if (faulted !== 1'b0) begin n_fail++; $display("FAIL load_faulted got %b exp 0", faulted); end
  endtask

  task automatic test_cfg_same_cycle();
    op = SPU_PUSH; step = 3'd1;
    cfg_we = 1'b1; cfg_lo = 16'h0200; cfg_hi = 16'h02FF;
    tick();
    idle();
    n_tests++; if (sp !== 16'h014F) begin n_fail++; $display("FAIL cfgsc_sp got %h exp 014F", sp); end
    n_tests++; if (faulted !== 1'b0) begin n_fail++; $display("FAIL cfgsc_faulted got %b exp 0", faulted); end
    n_tests++; if (depth !== 16'h01B0) begin n_fail++; $display("FAIL cfgsc_depth got %h exp 01B0", depth); end
    op = SPU_PUSH; step = 3'd1;
    tick();
    n_tests++; if (fault_cause !== SPF_OVERFLOW) begin n_fail++; $display("FAIL cfgsc_ovf got %0d exp 1", fault_cause); end
    n_tests++; if (sp !== 16'h014F) begin n_fail++; $display("FAIL cfgsc_ovf_sp got %h exp 014F", sp); end
    idle(); fault_clear = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_inverted_and_combo();
    cfg_we = 1'b1; cfg_lo = 16'h0300; cfg_hi = 16'h0100;
    tick();
    idle(); op = SPU_PUSH; step = 3'd0;
    tick();
    n_tests++; if (faulted !== 1'b0) begin n_fail++; $display("FAIL step0_faulted got %b exp 0", faulted); end
    n_tests++; if (sp !== 16'h014F) begin n_fail++; $display("FAIL step0_sp got %h exp 014F", sp); end
    op = SPU_POP; step = 3'd1;
    tick();
    n_tests++; if (fault_cause !== SPF_UNDERFLOW) begin n_fail++; $display("FAIL inv_cause got %0d exp 2", fault_cause); end
    idle();
    cfg_we = 1'b1; cfg_lo = 16'h0000; cfg_hi = 16'hFFFF;
    fault_clear = 1'b1; op = SPU_PUSH; step = 3'd2;
    tick();
    idle();
    n_tests++; if (faulted !== 1'b0) begin n_fail++; $display("FAIL combo_faulted got %b exp 0", faulted); end
    n_tests++; if (sp !== 16'h014F) begin n_fail++; $display("FAIL combo_sp got %h exp 014F", sp); end
    n_tests++; if (hwm !== 16'h014F) begin n_fail++; $display("FAIL combo_hwm got %h exp 014F", hwm); end
    op = SPU_PUSH; step = 3'd2;
    #1;
    n_tests++; if (stack_addr !== 16'h014D) begin n_fail++; $display("FAIL combo_addr got %h exp 014D", stack_addr); end
    tick();
    idle();
    n_tests++; if (sp !== 16'h014D) begin n_fail++; $display("FAIL combo_push_sp got %h exp 014D", sp); end
    n_tests++; if (depth !== 16'hFEB2) begin n_fail++; $display("FAIL combo_depth got %h exp FEB2", depth); end
    n_tests++; if (hwm !== 16'h014D) begin n_fail++; $display("FAIL combo_push_hwm got %h exp 014D", hwm); end
  endtask

  task automatic test_reset_mid_push();
    op = SPU_PUSH; step = 3'd4;
    #2;
    rst_async = 1'b0;
    #1;
    n_tests++; if (sp !== 16'hFFFF) begin n_fail++; $display("FAIL async_rst_sp got %h exp FFFF", sp); end
    n_tests++; if (hwm !== 16'hFFFF) begin n_fail++; $display("FAIL async_rst_hwm got %h exp FFFF", hwm); end
    n_tests++; if (depth !== 16'h0000) begin n_fail++; $display("FAIL async_rst_depth got %h exp 0000", depth); end
    idle();
    tick();
    rst_async = 1'b1;
    tick();
    n_tests++; if (sp !== 16'hFFFF) begin n_fail++; $display("FAIL post_rst_sp got %h exp FFFF", sp); end
    n_tests++; if (faulted !== 1'b0) begin n_fail++; $display("FAIL post_rst_faulted got %b exp 0", faulted); end
  endtask

  initial begin
    rst_async = 1'b0;
    idle();
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_load();
    test_cfg_same_cycle();
    test_inverted_and_combo();
    test_reset_mid_push();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sp_unit.md
Name: sp_unit

Overview:
- Parametrised stack-pointer unit for the vgacpu core. It replaces fixed SP_INC_1/2 and SP_DEC_1/2 stepping with a variable step, a direct load, and programmable stack bounds.
- Bounds are checked on every operation, with a sticky fault state machine and a high-water-mark tracker.
- Sits between the control unit and the data-memory address mux. Stack grows downward: push pre-decrements, pop post-increments.

Parameters:
- SP_WIDTH, 16, width of the stack pointer, limits and addresses.
- STEP_WIDTH, 3, width of the step input (max step 2^STEP_WIDTH-1).
- RESET_SP, 16'hFFFF, SP value after reset; must lie within the reset bounds.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_async  in  1  reset, asynchronous, active-low.
- op  in  sp_unit_op_t  operation this cycle.
- step  in  STEP_WIDTH  byte count for PUSH/POP; step=0 is legal and acts as NOP with no bound check.
- load_val  in  SP_WIDTH  value for SPU_LOAD.
- cfg_we  in  1  write limit_lo/limit_hi from cfg_lo/cfg_hi.
- cfg_lo  in  SP_WIDTH  new lower bound (inclusive).
- cfg_hi  in  SP_WIDTH  new upper bound (inclusive).
- fault_clear  in  1  return from FAULT to RUN and reset the high-water mark to the current SP.
- sp  out  SP_WIDTH  registered stack pointer.
- stack_addr  out  SP_WIDTH  combinational memory address for this cycle's op.
- depth  out  SP_WIDTH  registered limit_hi - sp, modulo 2^SP_WIDTH.
- hwm  out  SP_WIDTH  lowest SP reached (deepest stack) since reset or fault_clear.
- faulted  out  1  high in FAULT state.
- fault_cause  out  sp_fault_t  reason for the current fault; SPF_NONE in RUN.

Behaviour:
- Reset (rst_async low, asynchronous):
  - sp=RESET_SP, limit_lo=0, limit_hi=all-ones, hwm=RESET_SP.
  - state=RUN, fault_cause=SPF_NONE, depth=limit_hi-RESET_SP.
  - Reset mid-operation discards the pending op.
- stack_addr:
  - PUSH: sp-step.
  - POP: sp.
  - LOAD: load_val.
  - Otherwise: sp.
  - Purely combinational, valid in the same cycle as op.
- Arithmetic:
  - Computed at SP_WIDTH+1 bits with step zero-extended.
  - PUSH overflows if sp-step borrows, or if sp-step < limit_lo.
  - POP underflows if sp+step carries out of SP_WIDTH, or if sp+step-1 > limit_hi (the popped bytes must lie within bounds).
  - LOAD is bad if load_val < limit_lo or load_val > limit_hi.
- State machine, RUN / FAULT:
  - RUN, legal op: sp updates at the next edge. Latency is 1 cycle: sp, depth and hwm reflect the op on the following cycle.
  - RUN, illegal op: sp unchanged; next state FAULT; fault_cause = SPF_OVERFLOW, SPF_UNDERFLOW or SPF_BAD_LOAD.
  - FAULT: all ops ignored and sp held; cfg_we still honoured; fault_cause held.
  - FAULT with fault_clear: next state RUN, fault_cause=SPF_NONE, hwm=sp.
  - fault_clear in RUN: only resets hwm=sp. If an op is also present, the op executes and hwm takes min(new sp, current sp).
- cfg_we:
  - Limits update at the next edge; ops in the same cycle are checked against the OLD limits.
  - Writing limits that exclude the current sp does not fault; the next op is checked normally.
  - cfg_lo > cfg_hi is accepted. Every PUSH/POP/LOAD with step≠0 then faults.
- hwm: updated to the new sp whenever the new sp < hwm.
- Simultaneous cfg_we + fault_clear + op in FAULT: limits update, state goes to RUN, op ignored.

Decomposition:
- cpu_common gains sp_unit_op_t {SPU_NOP, SPU_PUSH, SPU_POP, SPU_LOAD} and sp_fault_t {SPF_NONE, SPF_OVERFLOW, SPF_UNDERFLOW, SPF_BAD_LOAD}.
- The legacy sp_operation_t stays for the current core.
- One sub-module: sp_bound_check, combinational. Inputs: op, sp, step, load_val, limits. Outputs: next_sp, legal, cause.
- sp_unit holds the registers and the FSM.

Test Plan:
- Reset with RESET_SP=16'hFFFF -> sp=FFFF, depth=0, hwm=FFFF, faulted=0; assert reset mid-PUSH -> sp returns to FFFF asynchronously.
- PUSH step=2 from FFFF -> stack_addr=FFFD same cycle, sp=FFFD next cycle, depth=2, hwm=FFFD; then POP step=2 -> stack_addr=FFFD, sp=FFFF, hwm stays FFFD.
- Limits lo=0100, hi=01FF, sp=0101, PUSH step=2 -> faulted=1, cause=SPF_OVERFLOW, sp stays 0101; subsequent POP ignored; fault_clear -> RUN, hwm=0101.
- sp=01FE, POP step=2 (last byte 01FF) -> legal, sp=0200; POP step=1 at 0200 -> SPF_UNDERFLOW.
- LOAD 0050 with lo=0100 -> SPF_BAD_LOAD, sp unchanged; LOAD 0150 -> sp=0150.
- cfg_we (lo=0200) in the same cycle as PUSH step=1 from 0150 with old lo=0100 -> PUSH legal (old limits), sp=014F; next PUSH -> SPF_OVERFLOW.
